// File: rtl/clz_radix2_div_core_pkg.sv
// rtl/clz_radix2_div_core_pkg.sv - shared constants for the CLZ-aligned radix-2 divider
package clz_radix2_div_core_pkg;

  // Operand/result width used when a block is not parameterised explicitly.
  localparam int DEFAULT_DIV_WIDTH = 32;

endpackage

// File: rtl/clz_radix2_div_core_if.sv
// rtl/clz_radix2_div_core_if.sv - request/result bundle between the div unit and the divider core
interface clz_radix2_div_core_if
  import clz_radix2_div_core_pkg::*;
#(
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
);

  localparam int CW = $clog2(DIV_WIDTH);

  logic                 start;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic [CW-1:0]        dividend_clz;
  logic [CW-1:0]        divisor_clz;
  logic                 divisor_is_zero;
  logic                 done;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;
  logic                 busy;

  // Requester side: issues operands, observes the result.
  modport master (
    output start, dividend, divisor, dividend_clz, divisor_clz, divisor_is_zero,
    input  done, quotient, remainder, busy
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor, dividend_clz, divisor_clz, divisor_is_zero,
    output done, quotient, remainder, busy
  );

endinterface

// File: rtl/clz_radix2_div_core.sv
// rtl/clz_radix2_div_core.sv - iterative unsigned restoring divider with CLZ-based iteration skipping
module clz_radix2_div_core
  import clz_radix2_div_core_pkg::*;
#(
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
  input logic                   clk,
  input logic                   rst,
  clz_radix2_div_core_if.slave  bus
);

  localparam int W  = DIV_WIDTH;
  localparam int CW = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t        state, state_next;
  logic [W-1:0]  r, r_next;        // partial remainder
  logic [W-1:0]  d, d_next;        // aligned divisor, shifts right each iteration
  logic [W-1:0]  q, q_next;        // quotient bits collected so far
  logic [CW-1:0] cnt, cnt_next;    // iterations left after the current one
  logic [W-1:0]  quo, quo_next;
  logic [W-1:0]  rem, rem_next;
  logic          done_q, done_next;
  logic [CW-1:0] k;
  logic          ge;

  // Next-state, iteration datapath and result capture.
  always_comb begin
    state_next = state;
    r_next     = r;
    d_next     = d;
    q_next     = q;
    cnt_next   = cnt;
    quo_next   = quo;
    rem_next   = rem;
    done_next  = 1'b0;
    // Alignment distance; only meaningful when divisor_clz >= dividend_clz.
    k          = bus.divisor_clz - bus.dividend_clz;
    // D never sits above the dividend's MSB, so a plain W-bit compare suffices.
    ge         = (r >= d);
    case (state)
      IDLE, HOLD: begin
        if (bus.start) begin
          if (bus.divisor_is_zero) begin
            quo_next   = '1;
            rem_next   = bus.dividend;
            done_next  = 1'b1;
            state_next = HOLD;
          end else if (bus.divisor_clz < bus.dividend_clz) begin
            quo_next   = '0;
            rem_next   = bus.dividend;
            done_next  = 1'b1;
            state_next = HOLD;
          end else begin
            r_next     = bus.dividend;
            d_next     = bus.divisor << k;
            q_next     = '0;
            cnt_next   = k;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (ge) r_next = r - d;
        q_next   = (q << 1) | {{(W-1){1'b0}}, ge};
        d_next   = d >> 1;
        cnt_next = cnt - CW'(1);
        if (cnt == '0) begin
          quo_next   = q_next;
          rem_next   = r_next;
          done_next  = 1'b1;
          state_next = HOLD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any division in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      r      <= '0;
      d      <= '0;
      q      <= '0;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      r      <= r_next;
      d      <= d_next;
      q      <= q_next;
      cnt    <= cnt_next;
      quo    <= quo_next;
      rem    <= rem_next;
      done_q <= done_next;
    end
  end

  assign bus.done      = done_q;
  assign bus.quotient  = quo;
  assign bus.remainder = rem;
  assign bus.busy      = (state == BUSY);

endmodule

// File: tb/tb_clz_radix2_div_core.sv
// tb/tb_clz_radix2_div_core.sv - scoreboard bench for the CLZ-aligned radix-2 divider
module tb_clz_radix2_div_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];

  clz_radix2_div_core_if #(.DIV_WIDTH(32)) bus ();

  clz_radix2_div_core #(.DIV_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending request (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 64'(bus.quotient), 64'(e.q));
        check("remainder", 64'(bus.remainder), 64'(e.r));
        check("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
      end
    end
  end

  // Called at a negedge; drives one start cycle and returns at the next negedge (cycle 1).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input int ca, input int cb,
                       input bit push, input logic [31:0] eq, input logic [31:0] er, input int lat);
    exp_t e;
    bus.start           = 1'b1;
    bus.dividend        = a;
    bus.divisor         = b;
    bus.dividend_clz    = 5'(ca);
    bus.divisor_clz     = 5'(cb);
    bus.divisor_is_zero = (b == 0);
    if (push) begin
      e.q = eq; e.r = er; e.start_cyc = cyc; e.lat = lat;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout_pending", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    bus.dividend_clz = '0;
    bus.divisor_clz = '0;
    bus.divisor_is_zero = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_quotient", 64'(bus.quotient), 64'd0);
    check("reset_remainder", 64'(bus.remainder), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 100/7, k=4: busy in cycles 1..5, done in cycle 6
    issue(32'd100, 32'd7, 25, 29, 1, 32'd14, 32'd2, 6);
    check("busy_c1", 64'(bus.busy), 64'd1);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      check("busy_mid", 64'(bus.busy), 64'd1);
    end
    @(negedge clk);
    check("busy_c6", 64'(bus.busy), 64'd0);
    wait_idle(10);
    repeat (3) @(negedge clk);
    check("hold_quotient", 64'(bus.quotient), 64'd14);
    check("hold_remainder", 64'(bus.remainder), 64'd2);

    // divide by zero
    issue(32'h1234, 32'd0, 0, 31, 1, 32'hFFFF_FFFF, 32'h1234, 1);
    wait_idle(10);
    @(negedge clk);

    // divisor > dividend, then 9/9 started in the same cycle as that done
    issue(32'd5, 32'd9, 29, 28, 1, 32'd0, 32'd5, 1);
    issue(32'd9, 32'd9, 28, 28, 1, 32'd1, 32'd0, 2);
    wait_idle(10);
    @(negedge clk);

    // worst case k=31 with ignored starts in cycles 1..32
    issue(32'hFFFF_FFFF, 32'd1, 0, 31, 1, 32'hFFFF_FFFF, 32'd0, 33);
    for (int i = 1; i <= 32; i++) begin
      bus.start = 1'b1;
      bus.dividend = 32'd7;
      bus.divisor = 32'd7;
      bus.dividend_clz = 5'd29;
      bus.divisor_clz = 5'd29;
      bus.divisor_is_zero = 1'b0;
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_idle(10);
    @(negedge clk);

    // back-to-back: 0/3 then 50/5 in the cycle after done
    issue(32'd0, 32'd3, 31, 30, 1, 32'd0, 32'd0, 1);
    @(negedge clk);
    check("b2b_hold_q", 64'(bus.quotient), 64'd0);
    issue(32'd50, 32'd5, 26, 29, 1, 32'd10, 32'd0, 5);
    check("b2b_busy_q", 64'(bus.quotient), 64'd0);
    check("b2b_busy_r", 64'(bus.remainder), 64'd0);
    wait_idle(10);
    @(negedge clk);

    // reset mid-operation: no done may appear
    issue(32'h8000_0000, 32'd1, 0, 31, 0, 32'd0, 32'd0, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_quotient", 64'(bus.quotient), 64'd0);
    check("abort_remainder", 64'(bus.remainder), 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd6, 32'd4, 29, 29, 1, 32'd1, 32'd2, 2);
    wait_idle(10);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
